// File: rtl/aes_block_ctrl.sv
// Host-side initiator for the AES core start/done interface: ECB/CBC chaining,
// one core operation per input block, result buffering and a completion watchdog.
module aes_block_ctrl #(
  parameter int unsigned TIMEOUT = 31
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_cfg_load,
  input  logic [1:0]   i_cfg_mode,
  input  logic         i_cfg_dec,
  input  logic         i_cfg_cbc,
  input  logic [255:0] i_cfg_key,
  input  logic [127:0] i_cfg_iv,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [127:0] i_in_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_out_data,
  output logic         o_core_start,
  output logic         o_core_enc_dec,
  output logic [1:0]   o_core_mode,
  output logic [255:0] o_core_key,
  output logic [127:0] o_core_data_in,
  input  logic [127:0] i_core_data_out,
  input  logic         i_core_done,
  output logic         o_busy,
  output logic         o_err
);

  localparam int unsigned WDOG_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StDrain} state_e;

  state_e             r_state, w_state_next;
  logic [1:0]         r_mode;
  logic               r_dec, r_cbc, r_err, r_out_valid;
  logic [255:0]       r_key;
  logic [127:0]       r_chain, r_ct, r_res, r_out_data, r_core_data_in;
  logic [WDOG_W-1:0]  r_wdog;

  logic               w_cfg_ok, w_accept, w_cbc_enc, w_cbc_dec;
  logic               w_out_load, w_to_drain, w_timeout;
  logic [127:0]       w_res, w_out_next;

  assign w_cbc_enc  = r_cbc & ~r_dec;
  assign w_cbc_dec  = r_cbc & r_dec;
  assign o_in_ready = i_rst_n & (r_state == StIdle) & ~i_cfg_load;
  assign w_accept   = i_in_valid & o_in_ready;
  // Configuration may only change while nothing is in flight or waiting to be read.
  assign w_cfg_ok   = i_cfg_load & (r_state == StIdle) & ~r_out_valid;
  assign w_res      = w_cbc_dec ? (i_core_data_out ^ r_chain) : i_core_data_out;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_out_load   = 1'b0;
    w_to_drain   = 1'b0;
    w_timeout    = 1'b0;
    w_out_next   = r_out_data;
    case (r_state)
      StIdle: begin
        if (w_accept) w_state_next = StStart;
      end
      StStart: begin
        w_state_next = StWait;
      end
      StWait: begin
        if (i_core_done) begin
          if (!r_out_valid || i_out_ready) begin
            w_out_load   = 1'b1;
            w_out_next   = w_res;
            w_state_next = StIdle;
          end else begin
            w_to_drain   = 1'b1;
            w_state_next = StDrain;
          end
        end else if (r_wdog == WDOG_W'(TIMEOUT - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = StIdle;
        end
      end
      StDrain: begin
        if (i_out_ready) begin
          w_out_load   = 1'b1;
          w_out_next   = r_res;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode         <= 2'b00;
      r_dec          <= 1'b0;
      r_cbc          <= 1'b0;
      r_key          <= '0;
      r_chain        <= '0;
      r_ct           <= '0;
      r_res          <= '0;
      r_core_data_in <= '0;
      r_out_data     <= '0;
      r_out_valid    <= 1'b0;
      r_wdog         <= '0;
      r_err          <= 1'b0;
    end else begin
      if (w_cfg_ok) begin
        r_mode  <= i_cfg_mode;
        r_dec   <= i_cfg_dec;
        r_cbc   <= i_cfg_cbc;
        r_key   <= i_cfg_key;
        r_chain <= i_cfg_iv;
        r_err   <= 1'b0;
      end
      if (w_accept) begin
        r_core_data_in <= w_cbc_enc ? (i_in_data ^ r_chain) : i_in_data;
        if (w_cbc_dec) r_ct <= i_in_data;
      end
      if (r_state == StStart) begin
        r_wdog <= '0;
      end else if (r_state == StWait) begin
        r_wdog <= r_wdog + 1'b1;
      end
      // Chain advances only on a real completion; an abandoned block leaves it intact.
      if ((r_state == StWait) && i_core_done) begin
        if (w_cbc_enc) begin
          r_chain <= i_core_data_out;
        end else if (w_cbc_dec) begin
          r_chain <= r_ct;
        end
      end
      if (w_to_drain) r_res <= w_res;
      if (w_out_load) begin
        r_out_data  <= w_out_next;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign o_out_valid    = r_out_valid;
  assign o_out_data     = r_out_data;
  assign o_core_start   = (r_state == StStart);
  assign o_core_enc_dec = r_dec;
  assign o_core_mode    = r_mode;
  assign o_core_key     = r_key;
  assign o_core_data_in = r_core_data_in;
  assign o_busy         = (r_state != StIdle) | r_out_valid;
  assign o_err          = r_err;

endmodule

// File: tb/tb_aes_block_ctrl.sv
// Bench for aes_block_ctrl: behavioural AES core stand-in, ECB/CBC reference model
// with scoreboard, directed latency/backpressure/watchdog/reset cases and a random phase.
module tb_aes_block_ctrl;
  localparam int unsigned TIMEOUT = 31;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_load = 1'b0, cfg_dec = 1'b0, cfg_cbc = 1'b0;
  logic [1:0]   cfg_mode = 2'b00;
  logic [255:0] cfg_key = '0;
  logic [127:0] cfg_iv = '0;
  logic         in_valid = 1'b0, in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid, out_ready = 1'b0;
  logic [127:0] out_data;
  logic         core_start, core_enc_dec, core_done, busy, err;
  logic [1:0]   core_mode;
  logic [255:0] core_key;
  logic [127:0] core_data_in, core_data_out;

  aes_block_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_load(cfg_load), .i_cfg_mode(cfg_mode),
    .i_cfg_dec(cfg_dec), .i_cfg_cbc(cfg_cbc), .i_cfg_key(cfg_key), .i_cfg_iv(cfg_iv),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_core_start(core_start), .o_core_enc_dec(core_enc_dec), .o_core_mode(core_mode),
    .o_core_key(core_key), .o_core_data_in(core_data_in), .i_core_data_out(core_data_out),
    .i_core_done(core_done), .o_busy(busy), .o_err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd128(), rnd128()};
  endfunction

  // Toy reversible keyed permutation standing in for the cipher.
  function automatic logic [127:0] f_enc(input logic [127:0] d, input logic [255:0] k);
    return {d[120:0], d[127:121]} ^ k[127:0] ^ k[255:128];
  endfunction

  function automatic logic [127:0] f_dec(input logic [127:0] d, input logic [255:0] k);
    logic [127:0] x;
    x = d ^ k[127:0] ^ k[255:128];
    return {x[6:0], x[127:7]};
  endfunction

  // Behavioural core: start at cycle t, done at t+L.
  bit           core_en = 1'b1;
  bit           lat_rand = 1'b0;
  int           core_lat = 11;
  int           c_cnt = 0;
  bit           c_pend = 1'b0;
  logic [127:0] c_res = '0;

  initial begin
    core_done = 1'b0;
    core_data_out = '0;
    forever begin
      @(posedge clk);
      #1;
      core_done = 1'b0;
      core_data_out = rnd128();
      if (c_pend) begin
        c_cnt--;
        if (c_cnt == 0) begin
          c_pend = 1'b0;
          core_done = 1'b1;
          core_data_out = c_res;
        end
      end
      if (core_start && core_en) begin
        c_pend = 1'b1;
        c_cnt = lat_rand ? int'($urandom_range(20, 1)) : core_lat;
        c_res = core_enc_dec ? f_dec(core_data_in, core_key) : f_enc(core_data_in, core_key);
      end
    end
  end

  // 0: hold low, 1: hold high, 2: random
  int rdy_mode = 1;
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = (rdy_mode == 2) ? ($urandom_range(3, 0) != 0) : (rdy_mode == 1);
  end

  // Reference model state.
  logic [1:0]   m_mode = 2'b00;
  logic         m_dec = 1'b0, m_cbc = 1'b0;
  logic [255:0] m_key = '0;
  logic [127:0] m_chain = '0;
  logic [127:0] q_cin[$];
  logic [127:0] q_out[$];
  logic [127:0] got_q[$];
  int           acc_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (core_start) begin
        if (q_cin.size() == 0) check("start_unexpected", 256'(core_start), 256'(0));
        else check("core_data_in", 256'(core_data_in), 256'(q_cin.pop_front()));
        check("core_key", core_key, m_key);
        check("core_mode", 256'(core_mode), 256'(m_mode));
        check("core_enc_dec", 256'(core_enc_dec), 256'(m_dec));
      end
      if (out_valid && out_ready) begin
        if (q_out.size() == 0) check("out_unexpected", 256'(out_valid), 256'(0));
        else check("out_data", 256'(out_data), 256'(q_out.pop_front()));
        got_q.push_back(out_data);
      end
    end
  end

  task automatic send(input logic [127:0] d);
    int n;
    logic [127:0] cin, r;
    n = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data = d;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 256'(in_ready), 256'(1));
    end else begin
      cin = (m_cbc && !m_dec) ? (d ^ m_chain) : d;
      q_cin.push_back(cin);
      if (core_en) begin
        if (!m_dec) r = f_enc(cin, m_key);
        else r = m_cbc ? (f_dec(d, m_key) ^ m_chain) : f_dec(d, m_key);
        q_out.push_back(r);
        if (m_cbc) m_chain = m_dec ? d : r;
      end
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_cfg(input logic [1:0] mode, input logic dec, input logic cbc,
                        input logic [255:0] key, input logic [127:0] iv, input logic with_valid);
    @(posedge clk);
    #1;
    cfg_load = 1'b1;
    cfg_mode = mode;
    cfg_dec = dec;
    cfg_cbc = cbc;
    cfg_key = key;
    cfg_iv = iv;
    in_valid = with_valid;
    in_data = rnd128();
    @(negedge clk);
    check("cfg_in_ready", 256'(in_ready), 256'(0));
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    in_valid = 1'b0;
    m_mode = mode;
    m_dec = dec;
    m_cbc = cbc;
    m_key = key;
    m_chain = iv;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 256'(busy), 256'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] key1, key2;
    logic [127:0] pt, iv, pt1, pt2, ct1, ct2, b1, b2;
    int s, n;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_in_ready", 256'(in_ready), 256'(0));
    check("rst_core_start", 256'(core_start), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_err", 256'(err), 256'(0));
    check("rst_out_data", 256'(out_data), 256'(0));
    check("rst_core_din", 256'(core_data_in), 256'(0));
    check("rst_core_key", core_key, 256'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 256'(in_ready), 256'(1));
    check("post_rst_busy", 256'(busy), 256'(0));

    // ECB encrypt with L=11
    key1 = rnd256();
    pt = 128'h00112233445566778899aabbccddeeff;
    do_cfg(2'b10, 1'b0, 1'b0, key1, '0, 1'b0);
    send(pt);
    @(negedge clk);
    check("ecb_core_start", 256'(core_start), 256'(1));
    check("ecb_core_din", 256'(core_data_in), 256'(pt));
    check("ecb_core_key", core_key, key1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ecb_latency", 256'(cyc - acc_cyc), 256'(13));
    check("ecb_out", 256'(out_data), 256'(f_enc(pt, key1)));
    wait_idle();

    // CBC encrypt, two blocks
    key2 = rnd256();
    iv = 128'h000102030405060708090a0b0c0d0e0f;
    pt1 = rnd128();
    pt2 = rnd128();
    ct1 = f_enc(pt1 ^ iv, key2);
    ct2 = f_enc(pt2 ^ ct1, key2);
    do_cfg(2'b00, 1'b0, 1'b1, key2, iv, 1'b0);
    got_q.delete();
    send(pt1);
    send(pt2);
    wait_idle();
    check("cbc_enc_count", 256'(got_q.size()), 256'(2));
    check("cbc_enc_ct1", 256'(got_q[0]), 256'(ct1));
    check("cbc_enc_ct2", 256'(got_q[1]), 256'(ct2));

    // CBC decrypt recovers the plaintexts
    do_cfg(2'b00, 1'b1, 1'b1, key2, iv, 1'b0);
    got_q.delete();
    send(ct1);
    send(ct2);
    wait_idle();
    check("cbc_dec_pt1", 256'(got_q[0]), 256'(pt1));
    check("cbc_dec_pt2", 256'(got_q[1]), 256'(pt2));

    // Backpressure across two blocks
    core_lat = 5;
    b1 = rnd128();
    b2 = rnd128();
    do_cfg(2'b01, 1'b0, 1'b0, key1, '0, 1'b0);
    got_q.delete();
    rdy_mode = 0;
    send(b1);
    send(b2);
    repeat (12) @(negedge clk);
    check("bp_in_ready", 256'(in_ready), 256'(0));
    check("bp_out_valid", 256'(out_valid), 256'(1));
    check("bp_busy", 256'(busy), 256'(1));
    check("bp_hold_data", 256'(out_data), 256'(f_enc(b1, key1)));
    rdy_mode = 1;
    wait_idle();
    check("bp_count", 256'(got_q.size()), 256'(2));
    check("bp_first", 256'(got_q[0]), 256'(f_enc(b1, key1)));
    check("bp_second", 256'(got_q[1]), 256'(f_enc(b2, key1)));

    // cfg_load wins over a simultaneous in_valid
    do_cfg(2'b00, 1'b0, 1'b1, key2, iv, 1'b1);
    @(negedge clk);
    check("cfg_wins_busy", 256'(busy), 256'(0));

    // Watchdog: core never completes; chain must survive the abandoned block
    core_en = 1'b0;
    send(rnd128());
    @(negedge clk);
    check("wd_core_start", 256'(core_start), 256'(1));
    s = cyc;
    n = 0;
    while (!err && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wd_err_time", 256'(cyc - s), 256'(TIMEOUT + 1));
    check("wd_in_ready", 256'(in_ready), 256'(1));
    check("wd_busy", 256'(busy), 256'(0));
    check("wd_out_valid", 256'(out_valid), 256'(0));
    core_en = 1'b1;
    send(rnd128());
    wait_idle();
    check("wd_err_sticky", 256'(err), 256'(1));
    do_cfg(2'b00, 1'b0, 1'b0, key1, '0, 1'b0);
    @(negedge clk);
    check("wd_err_cleared", 256'(err), 256'(0));

    // Random phase
    lat_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i % 10 == 0) begin
        rdy_mode = 1;
        wait_idle();
        do_cfg(2'($urandom_range(3, 0)), 1'($urandom), 1'($urandom), rnd256(), rnd128(),
               1'($urandom));
        rdy_mode = 2;
      end
      send(rnd128());
      repeat ($urandom_range(2, 0)) @(posedge clk);
    end
    rdy_mode = 1;
    wait_idle();
    check("rand_out_drained", 256'(q_out.size()), 256'(0));
    check("rand_cin_drained", 256'(q_cin.size()), 256'(0));

    // Reset in the middle of WAIT; the late core_done must be ignored
    lat_rand = 1'b0;
    core_lat = 20;
    send(rnd128());
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q_out.delete();
    q_cin.delete();
    m_mode = 2'b00;
    m_dec = 1'b0;
    m_cbc = 1'b0;
    m_key = '0;
    m_chain = '0;
    @(negedge clk);
    check("mid_rst_out_valid", 256'(out_valid), 256'(0));
    check("mid_rst_busy", 256'(busy), 256'(0));
    check("mid_rst_in_ready", 256'(in_ready), 256'(0));
    check("mid_rst_core_din", 256'(core_data_in), 256'(0));
    check("mid_rst_key", core_key, 256'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_release_ready", 256'(in_ready), 256'(1));
    repeat (25) @(negedge clk);
    check("late_done_out_valid", 256'(out_valid), 256'(0));
    check("late_done_busy", 256'(busy), 256'(0));
    core_lat = 3;
    do_cfg(2'b00, 1'b0, 1'b0, key2, '0, 1'b0);
    send(rnd128());
    wait_idle();
    check("final_drained", 256'(q_out.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
